// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and encodings for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_IF   = 2'd1,
    WAIT_DM   = 2'd2,
    WAIT_KILL = 2'd3
  } state_t;

  localparam logic [1:0] SIZE_BYTE   = 2'b00;
  localparam logic [1:0] SIZE_HALF   = 2'b01;
  localparam logic [1:0] SIZE_WORD   = 2'b10;
  localparam logic [1:0] SIZE_DOUBLE = 2'b11;

  localparam logic [1:0] FETCH_SIZE  = SIZE_WORD;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data requests onto one single-outstanding memory port.
// Latency: request to mem_* is combinational in IDLE; responses pass through combinationally.
// Backpressure: requesters hold until *_gnt; stall_if/stall_mem tell the pipeline to wait.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              flush,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [63:0]       dm_wdata,
  input  logic [1:0]        dm_size,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [63:0]       dm_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  output logic [1:0]        mem_size,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [63:0]       mem_rdata,
  output logic              stall_if,
  output logic              stall_mem
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  state_t           state;
  logic [CNT_W-1:0] starve_cnt;
  logic             idle;
  logic             sel_if;
  logic             sel_dm;

  // Data wins by default; fetch takes over once data has won STARVE_LIMIT times under contention.
  assign idle   = (state == IDLE) && !rst;
  assign sel_if = idle && if_req && !flush && (!dm_req || starve_cnt == CNT_MAX);
  assign sel_dm = idle && dm_req && !sel_if;

  assign mem_req   = sel_if || sel_dm;
  assign mem_we    = sel_dm && dm_we;
  assign mem_addr  = sel_dm ? dm_addr : (sel_if ? if_addr : '0);
  assign mem_wdata = sel_dm ? dm_wdata : '0;
  assign mem_size  = sel_dm ? dm_size : (sel_if ? FETCH_SIZE : 2'b00);

  assign if_gnt = mem_gnt && sel_if;
  assign dm_gnt = mem_gnt && sel_dm;

  assign if_rvalid = !rst && (state == WAIT_IF) && mem_rvalid && !flush;
  assign dm_rvalid = !rst && (state == WAIT_DM) && mem_rvalid;
  assign if_rdata  = if_rvalid ? mem_rdata[31:0] : '0;
  assign dm_rdata  = dm_rvalid ? mem_rdata : '0;

  assign stall_if  = !rst && ((if_req && !if_rvalid) || (state == WAIT_KILL));
  assign stall_mem = !rst && dm_req && !dm_rvalid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (if_gnt) begin
            state      <= WAIT_IF;
            starve_cnt <= '0;
          end else if (dm_gnt) begin
            state <= WAIT_DM;
            if (if_req && starve_cnt != CNT_MAX)
              starve_cnt <= CNT_W'(starve_cnt + 1'b1);
          end
        end
        // A flush with no response yet leaves a fetch response that must be swallowed.
        WAIT_IF: begin
          if (mem_rvalid)
            state <= IDLE;
          else if (flush)
            state <= WAIT_KILL;
        end
        WAIT_DM, WAIT_KILL: begin
          if (mem_rvalid)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus randomized traffic checked against a transaction-level model.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int AW  = 64;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req = 1'b0, flush = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
  logic [AW-1:0] if_addr = '0, dm_addr = '0;
  logic [63:0]   dm_wdata = '0, mem_rdata = '0;
  logic [1:0]    dm_size = 2'b00;
  logic          mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic          if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_req, mem_we, stall_if, stall_mem;
  logic [31:0]   if_rdata;
  logic [63:0]   dm_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [1:0]    mem_size;

  mem_port_arbiter #(.ADDR_W(AW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .flush(flush),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_size(dm_size),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_size(mem_size),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: who owns the single outstanding transaction (0 none, 1 fetch, 2 data), and whether a fetch was cancelled.
  int m_owner  = 0;
  bit m_kill   = 1'b0;
  int m_starve = 0;

  logic          e_if_gnt, e_dm_gnt, e_if_rvalid, e_dm_rvalid, e_mem_req, e_mem_we, e_stall_if, e_stall_mem;
  logic [31:0]   e_if_rdata;
  logic [63:0]   e_dm_rdata, e_mem_wdata;
  logic [AW-1:0] e_mem_addr;
  logic [1:0]    e_mem_size;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    logic s_if, s_dm;
    @(negedge clk);
    s_if = 1'b0; s_dm = 1'b0;
    e_if_gnt = 1'b0; e_dm_gnt = 1'b0; e_if_rvalid = 1'b0; e_dm_rvalid = 1'b0;
    e_mem_req = 1'b0; e_mem_we = 1'b0; e_stall_if = 1'b0; e_stall_mem = 1'b0;
    e_if_rdata = '0; e_dm_rdata = '0; e_mem_wdata = '0; e_mem_addr = '0; e_mem_size = 2'b00;
    if (!rst) begin
      if (m_owner == 0) begin
        s_if = if_req && !flush && (!dm_req || m_starve == LIM);
        s_dm = dm_req && !s_if;
        e_mem_req   = s_if || s_dm;
        e_mem_we    = s_dm && dm_we;
        e_mem_addr  = s_dm ? dm_addr : (s_if ? if_addr : '0);
        e_mem_wdata = s_dm ? dm_wdata : '0;
        e_mem_size  = s_dm ? dm_size : (s_if ? 2'b10 : 2'b00);
        e_if_gnt    = s_if && mem_gnt;
        e_dm_gnt    = s_dm && mem_gnt;
      end else if (mem_rvalid) begin
        if (m_owner == 1 && !m_kill && !flush) begin
          e_if_rvalid = 1'b1;
          e_if_rdata  = mem_rdata[31:0];
        end
        if (m_owner == 2) begin
          e_dm_rvalid = 1'b1;
          e_dm_rdata  = mem_rdata;
        end
      end
      e_stall_if  = (if_req && !e_if_rvalid) || (m_owner == 1 && m_kill);
      e_stall_mem = dm_req && !e_dm_rvalid;
    end
    chk("if_gnt", if_gnt, e_if_gnt);
    chk("dm_gnt", dm_gnt, e_dm_gnt);
    chk("if_rvalid", if_rvalid, e_if_rvalid);
    chk("if_rdata", if_rdata, e_if_rdata);
    chk("dm_rvalid", dm_rvalid, e_dm_rvalid);
    chk("dm_rdata", dm_rdata, e_dm_rdata);
    chk("mem_req", mem_req, e_mem_req);
    chk("mem_we", mem_we, e_mem_we);
    chk("mem_addr", mem_addr, e_mem_addr);
    chk("mem_wdata", mem_wdata, e_mem_wdata);
    chk("mem_size", mem_size, e_mem_size);
    chk("stall_if", stall_if, e_stall_if);
    chk("stall_mem", stall_mem, e_stall_mem);
    chk("starve_cnt", dut.starve_cnt, m_starve);
  endtask

  task automatic advance();
    @(posedge clk);
    if (rst) begin
      m_owner = 0; m_kill = 1'b0; m_starve = 0;
    end else if (m_owner == 0) begin
      if (e_if_gnt) begin
        m_owner = 1; m_starve = 0;
      end else if (e_dm_gnt) begin
        m_owner = 2;
        if (if_req && m_starve < LIM) m_starve++;
      end
    end else if (mem_rvalid) begin
      m_owner = 0; m_kill = 1'b0;
    end else if (m_owner == 1 && flush) begin
      m_kill = 1'b1;
    end
    #1;
  endtask

  task automatic cycle();
    sample();
    advance();
  endtask

  initial begin
    int who;
    // Reset
    cycle();
    sample();
    chk("rst_mem_req", mem_req, 1'b0);
    advance();
    rst = 1'b0;

    // Fetch only
    if_req = 1'b1; if_addr = 64'h100; mem_gnt = 1'b1;
    sample();
    chk("fetch_gnt_c0", if_gnt, 1'b1);
    chk("fetch_stall_c0", stall_if, 1'b1);
    advance();
    sample();
    chk("fetch_stall_c1", stall_if, 1'b1);
    advance();
    mem_rvalid = 1'b1; mem_rdata = 64'h00500093;
    sample();
    chk("fetch_rvalid_c2", if_rvalid, 1'b1);
    chk("fetch_rdata_c2", if_rdata, 32'h00500093);
    advance();
    mem_rvalid = 1'b0; if_req = 1'b0;

    // Contention: data wins LIM times, then fetch
    if_req = 1'b1; if_addr = 64'h200; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h2000; dm_size = SIZE_DOUBLE;
    for (int i = 0; i < LIM + 1; i++) begin
      sample();
      who = dm_gnt ? 2 : (if_gnt ? 1 : 0);
      chk("contend_grant", who, (i < LIM) ? 2 : 1);
      advance();
      mem_rvalid = 1'b1; mem_rdata = 64'h1111_0000 + i;
      cycle();
      mem_rvalid = 1'b0;
    end
    chk("contend_starve_clear", dut.starve_cnt, 0);
    dm_req = 1'b0; if_req = 1'b0;

    // Flush while fetch in flight
    if_req = 1'b1; if_addr = 64'h300;
    cycle();
    if_req = 1'b0; flush = 1'b1;
    cycle();
    flush = 1'b0;
    sample();
    chk("kill_stall_if", stall_if, 1'b1);
    advance();
    mem_rvalid = 1'b1; mem_rdata = 64'hBAD0BAD0;
    sample();
    chk("kill_no_rvalid", if_rvalid, 1'b0);
    advance();
    mem_rvalid = 1'b0; if_req = 1'b1; if_addr = 64'h104;
    sample();
    chk("kill_next_gnt", if_gnt, 1'b1);
    advance();
    mem_rvalid = 1'b1; mem_rdata = 64'h00A00113;
    sample();
    chk("kill_next_rvalid", if_rvalid, 1'b1);
    advance();
    mem_rvalid = 1'b0;

    // Flush coincident with response
    if_addr = 64'h400;
    cycle();
    flush = 1'b1; mem_rvalid = 1'b1; mem_rdata = 64'h12345678;
    sample();
    chk("coinc_no_rvalid", if_rvalid, 1'b0);
    advance();
    flush = 1'b0; mem_rvalid = 1'b0;
    sample();
    chk("coinc_idle_gnt", if_gnt, 1'b1);
    advance();
    mem_rvalid = 1'b1;
    cycle();
    mem_rvalid = 1'b0; if_req = 1'b0;

    // Store acknowledge
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 64'h3008; dm_wdata = 64'hDEADBEEF; dm_size = SIZE_DOUBLE;
    sample();
    chk("store_we", mem_we, 1'b1);
    chk("store_addr", mem_addr, 64'h3008);
    chk("store_wdata", mem_wdata, 64'hDEADBEEF);
    chk("store_size", mem_size, 2'b11);
    chk("store_gnt", dm_gnt, 1'b1);
    advance();
    sample();
    chk("store_stall", stall_mem, 1'b1);
    advance();
    mem_rvalid = 1'b1; mem_rdata = 64'h0;
    sample();
    chk("store_ack", dm_rvalid, 1'b1);
    chk("store_stall_fall", stall_mem, 1'b0);
    advance();
    mem_rvalid = 1'b0; dm_we = 1'b0;

    // Reset mid-transaction
    dm_addr = 64'h5000;
    cycle();
    rst = 1'b1;
    sample();
    chk("rstmid_dm_rvalid", dm_rvalid, 1'b0);
    chk("rstmid_stall_mem", stall_mem, 1'b0);
    advance();
    rst = 1'b0; dm_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'hFEED;
    sample();
    chk("rstmid_stale", dm_rvalid, 1'b0);
    advance();
    mem_rvalid = 1'b0; dm_req = 1'b1;
    sample();
    chk("rstmid_regrant", dm_gnt, 1'b1);
    advance();
    mem_rvalid = 1'b1;
    cycle();
    mem_rvalid = 1'b0; dm_req = 1'b0;

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      rst        = ($urandom_range(0, 49) == 0);
      if_req     = ($urandom_range(0, 3) != 0);
      if_addr    = {$urandom, $urandom};
      dm_req     = ($urandom_range(0, 3) != 0);
      dm_we      = $urandom_range(0, 1);
      dm_addr    = {$urandom, $urandom};
      dm_wdata   = {$urandom, $urandom};
      dm_size    = 2'($urandom_range(0, 3));
      flush      = ($urandom_range(0, 5) == 0);
      mem_gnt    = ($urandom_range(0, 2) != 0);
      mem_rvalid = ($urandom_range(0, 2) == 0);
      mem_rdata  = {$urandom, $urandom};
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
